uc_debug_ctrl: RTL

//  Control unit for the single-cycle 8-bit microcontroller datapath.
//  - Decodes the 6-bit Opcode and the registered zero flag z into s_inc, s_inm, we3, wez and Op.
//  - Adds a run/halt/single-step debug FSM and a retired-instruction counter.
//  - Drives cpu_en; while cpu_en=0 the datapath holds its PC, register file and z flag.

---
 rtl/uc_debug_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/uc_debug_ctrl.sv
// Control unit for the single-cycle 8-bit microcontroller: opcode decode, run/halt/step debug FSM, retired counter.
// Optional feature: define UC_ILLEGAL_TRAP_EN to trap illegal opcodes into HALTED instead of executing them as NOP.
module uc_debug_ctrl #(
    parameter int CNT_W       = 16,
    parameter bit BOOT_HALTED = 1'b0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [5:0]       Opcode_i,
    input  logic             z_i,
    output logic             s_inc_o,
    output logic             s_inm_o,
    output logic             we3_o,
    output logic             wez_o,
    output logic [2:0]       Op_o,
    output logic             cpu_en_o,
    input  logic             run_req_i,
    input  logic             step_req_i,
    input  logic             halt_req_i,
    output logic             halted_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] retired_o
);

    localparam logic [2:0] ST_BOOT   = 3'd0;
    localparam logic [2:0] ST_RUN    = 3'd1;
    localparam logic [2:0] ST_HALTED = 3'd2;
    localparam logic [2:0] ST_STEP   = 3'd3;
    localparam logic [2:0] ST_RESUME = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic isAlu, isLoadi, isJmp, isJz, isJnz, isHalt;
    logic execState;
    logic trapHit;
    logic cpuEn;

    always_comb begin
        isAlu   = (Opcode_i[5:3] == 3'b001);
        isLoadi = (Opcode_i[5:2] == 4'b0100);
        isJmp   = (Opcode_i == 6'b010100);
        isJz    = (Opcode_i == 6'b010101);
        isJnz   = (Opcode_i == 6'b010110);
        isHalt  = (Opcode_i == 6'b111111);
    end

    assign execState = (state_q == ST_RUN) || (state_q == ST_STEP) || (state_q == ST_RESUME);

`ifdef UC_ILLEGAL_TRAP_EN
    logic isNop, isLegal;
    logic illegal_q, illegal_d;

    assign isNop   = (Opcode_i == 6'b000000);
    assign isLegal = isAlu | isLoadi | isJmp | isJz | isJnz | isNop | isHalt;
    assign trapHit = execState & ~isLegal;

    // Sticky trap flag: only a reset clears it.
    always_comb begin
        illegal_d = illegal_q | trapHit;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal_o = illegal_q;
`else
    assign trapHit   = 1'b0;
    assign illegal_o = 1'b0;
`endif

    // HALT stalls only in RUN; in STEP/RESUME it retires as a NOP so the PC can move past it.
    always_comb begin
        cpuEn = 1'b0;
        case (state_q)
            ST_RUN:              cpuEn = ~isHalt & ~trapHit;
            ST_STEP, ST_RESUME:  cpuEn = ~trapHit;
            default:             cpuEn = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: begin
                state_d = BOOT_HALTED ? ST_HALTED : ST_RUN;
            end
            ST_RUN: begin
                if (isHalt || trapHit || halt_req_i) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (halt_req_i) begin
                    state_d = ST_HALTED;
                end else if (run_req_i) begin
                    state_d = ST_RESUME;
                end else if (step_req_i) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                state_d = ST_HALTED;
            end
            ST_RESUME: begin
                state_d = trapHit ? ST_HALTED : ST_RUN;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_comb begin
        retired_d = retired_q;
        if (cpuEn && (retired_q != {CNT_W{1'b1}})) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_BOOT;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Datapath controls fall back to a harmless NOP whenever the datapath is frozen.
    always_comb begin
        s_inc_o = 1'b1;
        s_inm_o = 1'b0;
        we3_o   = 1'b0;
        wez_o   = 1'b0;
        Op_o    = 3'b000;
        if (cpuEn) begin
            if (isAlu) begin
                Op_o  = Opcode_i[2:0];
                we3_o = 1'b1;
                wez_o = 1'b1;
            end else if (isLoadi) begin
                s_inm_o = 1'b1;
                we3_o   = 1'b1;
            end else if (isJmp) begin
                s_inc_o = 1'b0;
            end else if (isJz) begin
                s_inc_o = ~z_i;
            end else if (isJnz) begin
                s_inc_o = z_i;
            end
        end
    end

    assign cpu_en_o  = cpuEn;
    assign halted_o  = (state_q == ST_HALTED);
    assign retired_o = retired_q;

    haltedFrozen: assert property (@(posedge clk_i) disable iff (reset_i) halted_o |-> !cpu_en_o);
    enOnlyExec:   assert property (@(posedge clk_i) disable iff (reset_i) cpu_en_o |-> execState);

endmodule
